// File: rtl/add_seq_pkg.sv
// Shared types and constants for the add_seq_arbiter slice.
// Optional rsp_ovf output is enabled by defining ADDSEQ_OVF_EN.
package add_seq_pkg;

  localparam int LIMB_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef logic req_id_t;

  // Limb counter width; a single-limb build still needs one bit.
  function automatic int limb_cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/add16_slice.sv
// Combinational 16-bit add slice; also exposes the carry into bit 15
// so the sequencer can derive signed overflow on the top limb.
module add16_slice
  import add_seq_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W-1:0] s,
  output logic              cout,
  output logic              c_msb
);

  logic [LIMB_W-1:0] lo;
  logic [1:0]        hi;

  // Low 15 bits first so the carry into the MSB is visible on its own.
  assign lo    = {1'b0, a[LIMB_W-2:0]} + {1'b0, b[LIMB_W-2:0]} + {{(LIMB_W-1){1'b0}}, cin};
  assign c_msb = lo[LIMB_W-1];
  assign hi    = {1'b0, a[LIMB_W-1]} + {1'b0, b[LIMB_W-1]} + {1'b0, c_msb};
  assign s     = {hi[0], lo[LIMB_W-2:0]};
  assign cout  = hi[1];

endmodule

// File: rtl/add_seq_arbiter.sv
// Two-requester arbiter that sequences WORDS-limb additions through one add16_slice.
// Define ADDSEQ_OVF_EN to add the registered signed-overflow output rsp_ovf.
module add_seq_arbiter
  import add_seq_pkg::*;
#(
  parameter  int WORDS = 2,
  localparam int OPW   = LIMB_W * WORDS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_a,
  input  logic [OPW-1:0] req0_b,
  input  logic           req0_cin,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_a,
  input  logic [OPW-1:0] req1_b,
  input  logic           req1_cin,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [OPW-1:0] rsp_sum,
  output logic           rsp_cout,
  output logic           rsp_id
`ifdef ADDSEQ_OVF_EN
  , output logic         rsp_ovf
`endif
);

  localparam int             CW   = limb_cnt_w(WORDS);
  localparam logic [CW-1:0]  LAST = CW'(WORDS - 1);

  logic [1:0]                    state;
  req_id_t                       last_grant;
  req_id_t                       id_q;
  req_id_t                       winner;
  logic [WORDS-1:0][LIMB_W-1:0]  a_q;
  logic [WORDS-1:0][LIMB_W-1:0]  b_q;
  logic [WORDS-1:0][LIMB_W-1:0]  sum_q;
  logic [CW-1:0]                 limb;
  logic                          carry;
  logic                          accept;

  logic [LIMB_W-1:0]             s_limb;
  logic                          s_cout;
`ifdef ADDSEQ_OVF_EN
  logic                          s_cmsb;
  logic                          ovf_q;
`else
  logic                          s_cmsb_unused;
`endif

  // Lone requester wins; on a tie the one not granted last time wins.
  // NOTE: winner gets a default before any branch so no latch is inferred.
  always_comb begin
    winner = ~last_grant;
    if (req0_valid && !req1_valid)
      winner = 1'b0;
    else if (req1_valid && !req0_valid)
      winner = 1'b1;
  end

  assign req0_ready = (state == ST_IDLE) && req0_valid && (winner == 1'b0);
  assign req1_ready = (state == ST_IDLE) && req1_valid && (winner == 1'b1);
  assign accept     = req0_ready || req1_ready;

  add16_slice u_slice (
    .a     (a_q[limb]),
    .b     (b_q[limb]),
    .cin   (carry),
    .s     (s_limb),
    .cout  (s_cout),
`ifdef ADDSEQ_OVF_EN
    .c_msb (s_cmsb)
`else
    .c_msb (s_cmsb_unused)
`endif
  );

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      limb       <= '0;
      carry      <= 1'b0;
`ifdef ADDSEQ_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q        <= winner ? req1_a   : req0_a;
            b_q        <= winner ? req1_b   : req0_b;
            carry      <= winner ? req1_cin : req0_cin;
            id_q       <= winner;
            last_grant <= winner;
            limb       <= '0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          sum_q[limb] <= s_limb;
          carry       <= s_cout;
          if (limb == LAST) begin
`ifdef ADDSEQ_OVF_EN
            ovf_q <= s_cmsb ^ s_cout;
`endif
            state <= ST_RESP;
          end else begin
            limb <= limb + CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The carry register doubles as the carry-out once the last limb is done.
  assign rsp_valid = (state == ST_RESP);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry;
  assign rsp_id    = id_q;
`ifdef ADDSEQ_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_arbiter.sv
// Scoreboard bench for add_seq_arbiter: a WORDS=2 instance with directed vectors
// and a WORDS=1 instance for single-limb latency.
module tb_add_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_cin, req1_cin;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [31:0] rsp_sum;
  logic        rsp_ovf;

  logic        w1_req0_valid, w1_req0_ready, w1_req1_ready;
  logic [15:0] w1_req0_a, w1_req0_b, w1_rsp_sum;
  logic        w1_req0_cin, w1_rsp_valid, w1_rsp_cout, w1_rsp_id, w1_rsp_ovf;

  always #5 clk = ~clk;

  add_seq_arbiter #(.WORDS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
`ifdef ADDSEQ_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  add_seq_arbiter #(.WORDS(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w1_req0_valid), .req0_ready(w1_req0_ready), .req0_a(w1_req0_a), .req0_b(w1_req0_b), .req0_cin(w1_req0_cin),
    .req1_valid(1'b0), .req1_ready(w1_req1_ready), .req1_a(16'h0), .req1_b(16'h0), .req1_cin(1'b0),
    .rsp_valid(w1_rsp_valid), .rsp_ready(1'b1), .rsp_sum(w1_rsp_sum), .rsp_cout(w1_rsp_cout), .rsp_id(w1_rsp_id)
`ifdef ADDSEQ_OVF_EN
    , .rsp_ovf(w1_rsp_ovf)
`endif
  );

`ifndef ADDSEQ_OVF_EN
  assign rsp_ovf    = 1'b0;
  assign w1_rsp_ovf = 1'b0;
`endif

  typedef struct {
    logic        id;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] e0_sum, e1_sum;
  logic        e0_cout, e1_cout, e0_ovf, e1_ovf;
  bit          alt_mode = 0;
  logic        alt_exp;
  int          n_alt, last_acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Acceptor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) sb.push_back('{1'b0, e0_sum, e0_cout, e0_ovf, cyc + 1});
      if (req1_valid && req1_ready) sb.push_back('{1'b1, e1_sum, e1_cout, e1_ovf, cyc + 1});
      if (alt_mode && (req0_ready || req1_ready)) begin
        check("alt_id", {63'd0, req1_ready}, {63'd0, alt_exp});
        if (last_acc >= 0) check("alt_spacing", 64'(cyc + 1 - last_acc), 64'd4);
        alt_exp  = ~alt_exp;
        last_acc = cyc + 1;
        n_alt++;
      end
    end
  end

  // Monitor: pops the scoreboard on every response handshake.
  logic        prev_valid = 1'b0;
  int          rise_cyc;
  logic [31:0] cap_sum;
  logic        cap_cout, cap_id;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      check("ready_excl", {63'd0, req0_ready & req1_ready}, 64'd0);
      if (rsp_valid && !prev_valid) begin
        rise_cyc = cyc;
        cap_sum  = rsp_sum;
        cap_cout = rsp_cout;
        cap_id   = rsp_id;
      end
      if (rsp_valid) begin
        check("ready_in_resp", {62'd0, req0_ready, req1_ready}, 64'd0);
        if (prev_valid) check("hold", {rsp_id, rsp_cout, rsp_sum}, {cap_id, cap_cout, cap_sum});
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_sum", rsp_sum, e.sum);
            check("rsp_cout", rsp_cout, e.cout);
            check("rsp_id", rsp_id, e.id);
`ifdef ADDSEQ_OVF_EN
            check("rsp_ovf", rsp_ovf, e.ovf);
`endif
            check("latency", 64'(rise_cyc - e.acc), 64'd2);
          end
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic [31:0] es, input logic ec, input logic eo);
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_cin = cin; e0_sum = es; e0_cout = ec; e0_ovf = eo; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_cin = cin; e1_sum = es; e1_cout = ec; e1_ovf = eo; req1_valid = 1'b1;
    end
  endtask

  task automatic wait_accept(input int id);
    bit got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("accept_timeout", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
    req1_a = 0; req1_b = 0; req1_cin = 0;
    e0_sum = 0; e1_sum = 0; e0_cout = 0; e1_cout = 0; e0_ovf = 0; e1_ovf = 0;
    w1_req0_valid = 0; w1_req0_a = 0; w1_req0_b = 0; w1_req0_cin = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {rsp_valid, rsp_cout, rsp_id, rsp_ovf, req0_ready, req1_ready, rsp_sum}, 64'd0);
    #1 rst_n = 1'b1;

    // Limb carry propagation, then wrap-around and signed overflow cases.
    drive(0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0); wait_accept(0); wait_drain();
    drive(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0); wait_accept(0); wait_drain();
    drive(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1); wait_accept(0); wait_drain();
    drive(1, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1); wait_accept(1); wait_drain();
    drive(1, 32'h12345678, 32'h87654321, 1'b1, 32'h9999999A, 1'b0, 1'b0); wait_accept(1); wait_drain();

    // Consumer stalls in RESP while the other requester waits.
    @(posedge clk); #1 rsp_ready = 1'b0;
    drive(0, 32'h00FF00FF, 32'h01010101, 1'b0, 32'h02000200, 1'b0, 1'b0); wait_accept(0);
    drive(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    begin
      bit seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (rsp_valid) begin seen = 1; break; end
      end
      check("stall_rsp_seen", {63'd0, seen}, 64'd1);
    end
    repeat (5) @(negedge clk);
    check("stall_still_valid", {63'd0, rsp_valid}, 64'd1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_accept(1); wait_drain();

    // Reset while BUSY discards the operation.
    drive(0, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0); wait_accept(0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midreset_out", {rsp_valid, rsp_cout, rsp_id, rsp_ovf, req0_ready, req1_ready, rsp_sum}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    begin
      bit seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1;
      end
      check("no_rsp_after_reset", {63'd0, seen}, 64'd0);
    end
    drive(0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0); wait_accept(0); wait_drain();

    // Both requesters valid from reset: strict alternation starting with req0.
    @(posedge clk); #1 rst_n = 1'b0;
    sb.delete();
    alt_exp = 1'b0; n_alt = 0; last_acc = -1; alt_mode = 1;
    drive(0, 32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0);
    drive(1, 32'hFFFF0000, 32'h00010000, 1'b0, 32'h00000000, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (n_alt >= 4) break;
    end
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    check("alt_count", 64'(n_alt), 64'd4);
    wait_drain();
    alt_mode = 0;

    // Single-limb build: one-cycle latency and carry out of the only limb.
    begin
      int  acc = 0;
      bit  got = 0;
      @(posedge clk); #1;
      w1_req0_a = 16'hFFFF; w1_req0_b = 16'h0000; w1_req0_cin = 1'b1; w1_req0_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (w1_req0_ready) begin acc = cyc + 1; got = 1; break; end
      end
      check("w1_accept", {63'd0, got}, 64'd1);
      @(posedge clk); #1 w1_req0_valid = 1'b0;
      got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (w1_rsp_valid) begin got = 1; break; end
      end
      check("w1_rsp_seen", {63'd0, got}, 64'd1);
      check("w1_latency", 64'(cyc - acc), 64'd1);
      check("w1_sum", {48'd0, w1_rsp_sum}, 64'h0000);
      check("w1_cout", {63'd0, w1_rsp_cout}, 64'd1);
      check("w1_id", {63'd0, w1_rsp_id}, 64'd0);
`ifdef ADDSEQ_OVF_EN
      check("w1_ovf", {63'd0, w1_rsp_ovf}, 64'd0);
`endif
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
